// File: rtl/trace_serdes.sv
// trace_serdes: trace lane deserialiser (write path) and serialiser (read path)
// between FPGA trace pins and trace-buffer memory, with trigger position capture.
// Optional feature macro: TRACE_SERDES_DROP_CNT_EN adds DROP_CNT_O, a saturating
// count of mode-0 store-register overwrites.
module trace_serdes #(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned MAX_TRACES = 8,
   parameter int unsigned NTRACE_W   = 2
) (
   input  logic                       FPGA_CLK_I,
   input  logic                       RST_NI,
   input  logic [1:0]                 MODE_I,
   input  logic [NTRACE_W-1:0]        NTRACE_I,
   input  logic                       FPGA_TRIG_I,
   input  logic [MAX_TRACES-1:0]      FPGA_TRACE_I,
   output logic                       FPGA_WRITE_READY_O,
   input  logic                       FPGA_READ_I,
   output logic [MAX_TRACES-1:0]      FPGA_STREAM_O,
   output logic                       FPGA_READ_VALID_O,
   output logic                       FPGA_DELAYED_TRIG_O,
   input  logic                       TRG_DELAYED_I,
   output logic                       TRG_EVENT_O,
   output logic [$clog2(WIDTH)-1:0]   EVENT_POS_O,
   output logic [WIDTH-1:0]           DATA_O,
   output logic                       STORE_O,
   input  logic                       STORE_PERM_I,
   input  logic [WIDTH-1:0]           DATA_I,
   output logic                       LOAD_REQUEST_O,
   input  logic                       LOAD_GRANT_I
`ifdef TRACE_SERDES_DROP_CNT_EN
   ,
   output logic [15:0]                DROP_CNT_O
`endif
);

   localparam int unsigned POS_W   = $clog2(WIDTH);
   localparam int unsigned CNT_W   = POS_W + 1;
   localparam int unsigned LOG_MAX = $clog2(MAX_TRACES);

   typedef enum logic [1:0] {
      MODE_TRACE = 2'd0,
      MODE_RW    = 2'd1,
      MODE_W     = 2'd2,
      MODE_R     = 2'd3
   } trg_mode_t;

   // configuration and control state
   trg_mode_t             mode;
   logic [NTRACE_W-1:0]   ntrace;
   logic                  active;
   logic                  dly_trig;

   // write path state
   logic [WIDTH-1:0]      acc;
   logic [POS_W-1:0]      wbeat;
   logic [WIDTH-1:0]      store_q;
   logic                  store_full;
   logic                  trg_event;
   logic [POS_W-1:0]      event_pos;

   // read path state
   logic [WIDTH-1:0]      pf;
   logic                  pf_full;
   logic [WIDTH-1:0]      sr;
   logic                  sr_full;
   logic [POS_W-1:0]      rbeat;

   // combinational helpers
   logic [CNT_W-1:0]      lane_cnt;
   logic [CNT_W-1:0]      top_shift;
   logic [POS_W-1:0]      last_beat;
   logic [MAX_TRACES-1:0] lane_mask;
   logic                  wr_path;
   logic                  rd_path;
   logic                  wbeat_last;
   logic                  store_fire;
   logic                  stall;
   logic                  beat_ok;
   logic                  word_done;
   logic [MAX_TRACES-1:0] lanes;
   logic [WIDTH-1:0]      word_next;
   logic                  rd_valid;
   logic                  rd_take;
   logic                  rbeat_last;
   logic                  load_req;
   logic                  load_take;
   logic                  sr_reload;
   logic [WIDTH-1:0]      stream_word;
   logic [MAX_TRACES-1:0] stream;

   // lane geometry, write-path handshake and read-path control
   always_comb begin
      lane_cnt    = CNT_W'(1) << ntrace;
      top_shift   = CNT_W'(WIDTH) - lane_cnt;
      last_beat   = POS_W'((CNT_W'(WIDTH) >> ntrace) - CNT_W'(1));
      lane_mask   = ~({MAX_TRACES{1'b1}} << lane_cnt);

      wr_path     = active && (mode != MODE_R);
      rd_path     = active && (mode != MODE_W);

      // the final beat of a word waits while the previous word is still held
      wbeat_last  = (wbeat == last_beat);
      store_fire  = wr_path && store_full && STORE_PERM_I;
      stall       = (mode != MODE_TRACE) && wbeat_last && store_full && !STORE_PERM_I;
      beat_ok     = wr_path && !stall;
      word_done   = beat_ok && wbeat_last;
      lanes       = FPGA_TRACE_I & lane_mask;
      // new beat enters at the top; after B beats beat k sits at bit k*L
      word_next   = (acc >> lane_cnt) | (WIDTH'(lanes) << top_shift);

      rd_valid    = rd_path && sr_full;
      rd_take     = rd_valid && ((mode == MODE_TRACE) || FPGA_READ_I);
      rbeat_last  = (rbeat == last_beat);
      load_req    = rd_path && !pf_full;
      load_take   = load_req && LOAD_GRANT_I;
      sr_reload   = rd_path && (!sr_full || (rd_take && rbeat_last));
      stream_word = sr >> (rbeat << ntrace);
      stream      = rd_valid ? (MAX_TRACES'(stream_word) & lane_mask) : '0;
   end

   assign FPGA_WRITE_READY_O  = beat_ok;
   assign STORE_O             = store_fire;
   assign DATA_O              = store_q;
   assign TRG_EVENT_O         = trg_event;
   assign EVENT_POS_O         = event_pos;
   assign LOAD_REQUEST_O      = load_req;
   assign FPGA_READ_VALID_O   = rd_valid;
   assign FPGA_STREAM_O       = stream;
   assign FPGA_DELAYED_TRIG_O = dly_trig;

   // mode/lane-count latch during reset, run flag, delayed trigger register
   always_ff @(posedge FPGA_CLK_I) begin
      if (!RST_NI) begin
         mode     <= trg_mode_t'(MODE_I);
         ntrace   <= (NTRACE_I > NTRACE_W'(LOG_MAX)) ? NTRACE_W'(LOG_MAX) : NTRACE_I;
         active   <= 1'b0;
         dly_trig <= 1'b0;
      end else begin
         active   <= 1'b1;
         dly_trig <= TRG_DELAYED_I;
      end
   end

   // beat assembly, double-buffered store register and trigger capture
   always_ff @(posedge FPGA_CLK_I) begin
      if (!RST_NI) begin
         acc        <= '0;
         wbeat      <= '0;
         store_q    <= '0;
         store_full <= 1'b0;
         trg_event  <= 1'b0;
         event_pos  <= '0;
      end else begin
         if (beat_ok) begin
            acc   <= word_next;
            wbeat <= wbeat_last ? '0 : wbeat + POS_W'(1);
         end
         if (word_done) begin
            store_q    <= word_next;
            store_full <= 1'b1;
         end else if (store_fire) begin
            store_full <= 1'b0;
         end
         if (beat_ok && FPGA_TRIG_I && !trg_event) begin
            trg_event <= 1'b1;
            event_pos <= wbeat << ntrace;
         end
      end
   end

   // prefetch register and stream register with beat counter
   always_ff @(posedge FPGA_CLK_I) begin
      if (!RST_NI) begin
         pf      <= '0;
         pf_full <= 1'b0;
         sr      <= '0;
         sr_full <= 1'b0;
         rbeat   <= '0;
      end else if (sr_reload) begin
         rbeat <= '0;
         if (pf_full) begin
            sr      <= pf;
            sr_full <= 1'b1;
            pf_full <= 1'b0;
         end else if (load_take) begin
            sr      <= DATA_I;
            sr_full <= 1'b1;
         end else begin
            sr_full <= 1'b0;
         end
      end else begin
         if (rd_take) begin
            rbeat <= rbeat + POS_W'(1);
         end
         if (load_take) begin
            pf      <= DATA_I;
            pf_full <= 1'b1;
         end
      end
   end

`ifdef TRACE_SERDES_DROP_CNT_EN
   logic        overwrite;
   logic [15:0] drop_cnt;

   assign overwrite  = word_done && store_full && !store_fire;
   assign DROP_CNT_O = drop_cnt;

   // saturating count of words lost to store-register overwrite
   always_ff @(posedge FPGA_CLK_I) begin
      if (!RST_NI) begin
         drop_cnt <= '0;
      end else if (overwrite && (drop_cnt != 16'hFFFF)) begin
         drop_cnt <= drop_cnt + 16'd1;
      end
   end
`endif

endmodule
